// File: rtl/hyperbus_pkg.sv
// Shared HyperBus device-side definitions: CA field positions, responder states
// and the register-space word addresses.
package hyperbus_pkg;

    localparam int unsigned CaBitRead   = 47;
    localparam int unsigned CaBitReg    = 46;
    localparam int unsigned CaBitLinear = 45;

    localparam logic [31:0] RegAddrId0 = 32'h0000_0000;
    localparam logic [31:0] RegAddrCr0 = 32'h0000_0800;

    typedef enum logic [2:0] {
        IDLE,
        CA,
        LAT,
        WDATA,
        RDATA
    } hyper_dev_state_e;

endpackage

// File: rtl/hyperbus_dev_regs.sv
// HyperBus device register space: read-only ID0 and a store-only CR0.
// Only instantiated when HYPERBUS_DEV_REG_SPACE_EN is defined.
module hyperbus_dev_regs
    import hyperbus_pkg::*;
#(
    parameter int unsigned AddrWidth = 16,
    parameter logic [15:0] IdValue   = 16'h0C81,
    parameter logic [15:0] Cr0Reset  = 16'h8F1F
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 we_i,
    input  logic [AddrWidth-1:0] addr_i,
    input  logic [15:0]          wdata_i,
    input  logic [1:0]           be_i,
    output logic [15:0]          rdata_o
);

    logic [15:0] cr0_q, cr0_d;
    logic        hit_id0, hit_cr0;

    assign hit_id0 = (addr_i == AddrWidth'(RegAddrId0));
    assign hit_cr0 = (addr_i == AddrWidth'(RegAddrCr0));

    always_comb begin
        cr0_d = cr0_q;
        if (clr_i) begin
            cr0_d = Cr0Reset;
        end else if (we_i && hit_cr0) begin
            if (be_i[1]) cr0_d[15:8] = wdata_i[15:8];
            if (be_i[0]) cr0_d[7:0]  = wdata_i[7:0];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cr0_q <= Cr0Reset;
        else         cr0_q <= cr0_d;
    end

    always_comb begin
        rdata_o = 16'h0000;
        if (hit_id0)      rdata_o = IdValue;
        else if (hit_cr0) rdata_o = cr0_q;
    end

endmodule

// File: rtl/hyperbus_dev_responder.sv
// HyperBus device-side responder: CA decode, fixed 2x latency, SRAM-backed bursts.
// Register space is built only when HYPERBUS_DEV_REG_SPACE_EN is defined.
module hyperbus_dev_responder
    import hyperbus_pkg::*;
#(
    parameter int unsigned AddrWidth = 16,
    parameter int unsigned Latency   = 6,
    parameter logic [15:0] IdValue   = 16'h0C81,
    parameter logic [15:0] Cr0Reset  = 16'h8F1F
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 hyper_cs_ni,
    input  logic                 hyper_ck_i,
    input  logic                 hyper_reset_ni,
    input  logic [7:0]           hyper_dq_i,
    output logic [7:0]           hyper_dq_o,
    output logic                 hyper_dq_oe_o,
    input  logic                 hyper_rwds_i,
    output logic                 hyper_rwds_o,
    output logic                 hyper_rwds_oe_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [15:0]          mem_wdata_o,
    output logic [1:0]           mem_be_o,
    input  logic [15:0]          mem_rdata_i
);

    localparam int unsigned LatEdges = 4 * Latency - 6;

    hyper_dev_state_e state_q, state_d;
    logic                 ck_q, cs_q, ck_edge;
    logic [2:0]           ca_cnt_q, ca_cnt_d;
    logic [39:0]          ca_q, ca_d;
    logic [47:0]          ca_full;
    logic [31:0]          word_addr_full;
    logic [AddrWidth-1:0] start_addr;
    logic [7:0]           lat_cnt_q, lat_cnt_d;
    logic                 is_read_q, is_read_d, is_reg_q, is_reg_d, is_linear_q, is_linear_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic                 byte_sel_q, byte_sel_d;
    logic [7:0]           hi_q, hi_d;
    logic                 mask_hi_q, mask_hi_d;
    logic [15:0]          rd_word_q, rd_word_d, cur_word, reg_rdata;
    logic                 rd_valid_q, rd_valid_d;
    logic [7:0]           dq_q, dq_d;
    logic                 dq_oe_q, dq_oe_d, rwds_q, rwds_d, rwds_oe_q, rwds_oe_d;
    logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [AddrWidth-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]          mem_wdata_q, mem_wdata_d;
    logic [1:0]           mem_be_q, mem_be_d;
    logic                 unused_ca;

    function automatic logic [AddrWidth-1:0] next_addr(input logic [AddrWidth-1:0] a,
                                                       input logic linear);
        if (linear) return a + AddrWidth'(1);
        return {a[AddrWidth-1:4], a[3:0] + 4'd1};
    endfunction

    assign ck_edge        = hyper_ck_i ^ ck_q;
    assign ca_full        = {ca_q, hyper_dq_i};
    assign word_addr_full = {ca_full[44:16], ca_full[2:0]};
    assign start_addr     = word_addr_full[AddrWidth-1:0];
    assign unused_ca      = ^{ca_full[15:3], word_addr_full};

    // The word requested last cycle is on mem_rdata_i now; bypass it so edges 2 clocks apart still work.
    assign cur_word = is_reg_q   ? reg_rdata :
                      rd_valid_q ? mem_rdata_i : rd_word_q;

`ifdef HYPERBUS_DEV_REG_SPACE_EN
    logic reg_we;

    assign reg_we = (state_q == WDATA) && ck_edge && byte_sel_q && is_reg_q &&
                    !hyper_cs_ni && hyper_reset_ni;

    hyperbus_dev_regs #(
        .AddrWidth(AddrWidth),
        .IdValue  (IdValue),
        .Cr0Reset (Cr0Reset)
    ) u_regs (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (~hyper_reset_ni),
        .we_i   (reg_we),
        .addr_i (addr_q),
        .wdata_i({hi_q, hyper_dq_i}),
        .be_i   (~{mask_hi_q, hyper_rwds_i}),
        .rdata_o(reg_rdata)
    );
`else
    logic [31:0] unused_params;

    assign unused_params = {IdValue, Cr0Reset};
    assign reg_rdata     = 16'h0000;
`endif

    always_comb begin
        state_d     = state_q;
        ca_cnt_d    = ca_cnt_q;
        ca_d        = ca_q;
        lat_cnt_d   = lat_cnt_q;
        is_read_d   = is_read_q;
        is_reg_d    = is_reg_q;
        is_linear_d = is_linear_q;
        addr_d      = addr_q;
        byte_sel_d  = byte_sel_q;
        hi_d        = hi_q;
        mask_hi_d   = mask_hi_q;
        rd_valid_d  = mem_req_q & ~mem_we_q;
        rd_word_d   = rd_valid_q ? mem_rdata_i : rd_word_q;
        dq_d        = dq_q;
        dq_oe_d     = dq_oe_q;
        rwds_d      = rwds_q;
        rwds_oe_d   = rwds_oe_q;
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        // CS high or host reset aborts from any state, dropping any half-received word.
        if (hyper_cs_ni || !hyper_reset_ni) begin
            state_d    = IDLE;
            byte_sel_d = 1'b0;
            dq_d       = 8'h00;
            dq_oe_d    = 1'b0;
            rwds_d     = 1'b0;
            rwds_oe_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cs_q) begin
                        state_d   = CA;
                        ca_cnt_d  = 3'd0;
                        rwds_d    = 1'b1;
                        rwds_oe_d = 1'b1;
                    end
                end
                CA: begin
                    if (ck_edge) begin
                        ca_d     = ca_full[39:0];
                        ca_cnt_d = ca_cnt_q + 3'd1;
                        if (ca_cnt_q == 3'd5) begin
                            is_read_d   = ca_full[CaBitRead];
                            is_reg_d    = ca_full[CaBitReg];
                            is_linear_d = ca_full[CaBitLinear];
                            addr_d      = start_addr;
                            byte_sel_d  = 1'b0;
                            rwds_d      = 1'b0;
                            rwds_oe_d   = 1'b0;
                            lat_cnt_d   = 8'(LatEdges);
                            if (!ca_full[CaBitRead] && ca_full[CaBitReg]) begin
                                state_d = WDATA;
                            end else begin
                                state_d = LAT;
                                if (ca_full[CaBitRead] && !ca_full[CaBitReg]) begin
                                    mem_req_d  = 1'b1;
                                    mem_addr_d = start_addr;
                                    addr_d     = next_addr(start_addr, ca_full[CaBitLinear]);
                                end
                            end
                        end
                    end
                end
                LAT: begin
                    if (ck_edge) begin
                        lat_cnt_d = lat_cnt_q - 8'd1;
                        if (lat_cnt_q == 8'd1) begin
                            byte_sel_d = 1'b0;
                            if (is_read_q) begin
                                state_d   = RDATA;
                                dq_oe_d   = 1'b1;
                                rwds_d    = 1'b0;
                                rwds_oe_d = 1'b1;
                            end else begin
                                state_d = WDATA;
                            end
                        end
                    end
                end
                WDATA: begin
                    if (ck_edge) begin
                        if (!byte_sel_q) begin
                            hi_d       = hyper_dq_i;
                            mask_hi_d  = hyper_rwds_i;
                            byte_sel_d = 1'b1;
                        end else begin
                            byte_sel_d = 1'b0;
                            if (!is_reg_q) begin
                                mem_req_d   = 1'b1;
                                mem_we_d    = 1'b1;
                                mem_addr_d  = addr_q;
                                mem_wdata_d = {hi_q, hyper_dq_i};
                                mem_be_d    = ~{mask_hi_q, hyper_rwds_i};
                                addr_d      = next_addr(addr_q, is_linear_q);
                            end
                        end
                    end
                end
                RDATA: begin
                    if (ck_edge) begin
                        rwds_d = ~rwds_q;
                        if (!byte_sel_q) begin
                            dq_d       = cur_word[15:8];
                            byte_sel_d = 1'b1;
                        end else begin
                            dq_d       = cur_word[7:0];
                            byte_sel_d = 1'b0;
                            if (!is_reg_q) begin
                                mem_req_d  = 1'b1;
                                mem_addr_d = addr_q;
                                addr_d     = next_addr(addr_q, is_linear_q);
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ck_q        <= 1'b0;
            cs_q        <= 1'b1;
            ca_cnt_q    <= 3'd0;
            ca_q        <= '0;
            lat_cnt_q   <= 8'd0;
            is_read_q   <= 1'b0;
            is_reg_q    <= 1'b0;
            is_linear_q <= 1'b0;
            addr_q      <= '0;
            byte_sel_q  <= 1'b0;
            hi_q        <= 8'h00;
            mask_hi_q   <= 1'b0;
            rd_word_q   <= 16'h0000;
            rd_valid_q  <= 1'b0;
            dq_q        <= 8'h00;
            dq_oe_q     <= 1'b0;
            rwds_q      <= 1'b0;
            rwds_oe_q   <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 16'h0000;
            mem_be_q    <= 2'b00;
        end else begin
            state_q     <= state_d;
            ck_q        <= hyper_ck_i;
            cs_q        <= hyper_cs_ni;
            ca_cnt_q    <= ca_cnt_d;
            ca_q        <= ca_d;
            lat_cnt_q   <= lat_cnt_d;
            is_read_q   <= is_read_d;
            is_reg_q    <= is_reg_d;
            is_linear_q <= is_linear_d;
            addr_q      <= addr_d;
            byte_sel_q  <= byte_sel_d;
            hi_q        <= hi_d;
            mask_hi_q   <= mask_hi_d;
            rd_word_q   <= rd_word_d;
            rd_valid_q  <= rd_valid_d;
            dq_q        <= dq_d;
            dq_oe_q     <= dq_oe_d;
            rwds_q      <= rwds_d;
            rwds_oe_q   <= rwds_oe_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign hyper_dq_o      = dq_q;
    assign hyper_dq_oe_o   = dq_oe_q;
    assign hyper_rwds_o    = rwds_q;
    assign hyper_rwds_oe_o = rwds_oe_q;
    assign mem_req_o       = mem_req_q;
    assign mem_we_o        = mem_we_q;
    assign mem_addr_o      = mem_addr_q;
    assign mem_wdata_o     = mem_wdata_q;
    assign mem_be_o        = mem_be_q;

endmodule

// File: tb/tb_hyperbus_dev_responder.sv
// Scoreboard bench for hyperbus_dev_responder: a host model drives CK/DQ, expected SRAM ops
// and read bytes are queued up front and popped by a monitor as the DUT presents them.
module tb_hyperbus_dev_responder;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          edgeNo;
    } mem_op_t;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        hyper_cs_ni, hyper_ck_i, hyper_reset_ni, hyper_rwds_i;
    logic [7:0]  hyper_dq_i, hyper_dq_o;
    logic        hyper_dq_oe_o, hyper_rwds_o, hyper_rwds_oe_o;
    logic        mem_req_o, mem_we_o;
    logic [15:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [1:0]  mem_be_o;

    logic [15:0] sram [0:65535];
    mem_op_t     memQ[$];
    logic [7:0]  byteQ[$];
    int          checks = 0;
    int          failures = 0;
    int          edgeCnt = 0;
    int          lastByteEdge = 0;
    bit          firstByte = 1'b0;
    int          halfClk = 3;

    always #5 clk_i = ~clk_i;

    hyperbus_dev_responder dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .hyper_cs_ni    (hyper_cs_ni),
        .hyper_ck_i     (hyper_ck_i),
        .hyper_reset_ni (hyper_reset_ni),
        .hyper_dq_i     (hyper_dq_i),
        .hyper_dq_o     (hyper_dq_o),
        .hyper_dq_oe_o  (hyper_dq_oe_o),
        .hyper_rwds_i   (hyper_rwds_i),
        .hyper_rwds_o   (hyper_rwds_o),
        .hyper_rwds_oe_o(hyper_rwds_oe_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_be_o       (mem_be_o),
        .mem_rdata_i    (mem_rdata_i)
    );

    always @(posedge clk_i) begin
        if (mem_req_o) begin
            if (mem_we_o) begin
                if (mem_be_o[1]) sram[mem_addr_o][15:8] <= mem_wdata_o[15:8];
                if (mem_be_o[0]) sram[mem_addr_o][7:0]  <= mem_wdata_o[7:0];
            end else begin
                mem_rdata_i <= sram[mem_addr_o];
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [47:0] buildCa(input logic rd, input logic rg, input logic lin,
                                           input logic [31:0] waddr);
        logic [47:0] c;
        c        = '0;
        c[47]    = rd;
        c[46]    = rg;
        c[45]    = lin;
        c[44:16] = waddr[31:3];
        c[2:0]   = waddr[2:0];
        return c;
    endfunction

    task automatic hostEdge(input logic [7:0] d, input logic m);
        hyper_dq_i   = d;
        hyper_rwds_i = m;
        hyper_ck_i   = ~hyper_ck_i;
        edgeCnt++;
        repeat (halfClk) @(negedge clk_i);
    endtask

    // One full transaction: CA, 18 latency edges unless it is a register write, then nBytes data edges.
    task automatic applyStimulus(input logic rd, input logic rg, input logic lin,
                                 input logic [31:0] waddr, input logic [3:0][15:0] wdata,
                                 input logic [3:0][1:0] wmask, input int nBytes);
        logic [47:0] ca;
        ca = buildCa(rd, rg, lin, waddr);
        @(negedge clk_i);
        hyper_cs_ni = 1'b0;
        edgeCnt     = 0;
        firstByte   = 1'b1;
        repeat (2) @(negedge clk_i);
        checkOutput("ca_rwds_oe", {31'b0, hyper_rwds_oe_o}, 32'd1);
        checkOutput("ca_rwds", {31'b0, hyper_rwds_o}, 32'd1);
        for (int i = 0; i < 6; i++) hostEdge(ca[47-8*i -: 8], 1'b0);
        if (rd || !rg) begin
            for (int i = 0; i < 18; i++) hostEdge(8'h00, 1'b0);
        end
        for (int i = 0; i < nBytes; i++) begin
            if (rd) hostEdge(8'h00, 1'b0);
            else if (i[0]) hostEdge(wdata[i/2][7:0], wmask[i/2][0]);
            else hostEdge(wdata[i/2][15:8], wmask[i/2][1]);
        end
        repeat (3) @(negedge clk_i);
        hyper_cs_ni = 1'b1;
        repeat (4) @(negedge clk_i);
        checkOutput("memq_drained", memQ.size(), 32'd0);
        checkOutput("byteq_drained", byteQ.size(), 32'd0);
        checkOutput("idle_dq_oe", {31'b0, hyper_dq_oe_o}, 32'd0);
        checkOutput("idle_rwds_oe", {31'b0, hyper_rwds_oe_o}, 32'd0);
    endtask

    task automatic pushOp(input logic we, input logic [15:0] a, input logic [15:0] d,
                          input logic [1:0] be, input int e);
        mem_op_t op;
        op.we = we; op.addr = a; op.wdata = d; op.be = be; op.edgeNo = e;
        memQ.push_back(op);
    endtask

    task automatic pushBytes(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) byteQ.push_back(bytes[63-8*i -: 8]);
    endtask

    initial begin : monitor
        logic    prevRwds;
        mem_op_t op;
        prevRwds = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            if (mem_req_o) begin
                if (memQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_mem_req actual we=%0b addr=0x%0h required none",
                             mem_we_o, mem_addr_o);
                end else begin
                    op = memQ.pop_front();
                    checkOutput("mem_we", {31'b0, mem_we_o}, {31'b0, op.we});
                    checkOutput("mem_addr", {16'b0, mem_addr_o}, {16'b0, op.addr});
                    checkOutput("mem_edge", edgeCnt, op.edgeNo);
                    if (op.we) begin
                        checkOutput("mem_wdata", {16'b0, mem_wdata_o}, {16'b0, op.wdata});
                        checkOutput("mem_be", {30'b0, mem_be_o}, {30'b0, op.be});
                    end
                end
            end
            if (hyper_dq_oe_o && hyper_rwds_oe_o && (hyper_rwds_o != prevRwds)) begin
                if (byteQ.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rd_byte actual=0x%0h required none", hyper_dq_o);
                end else begin
                    checkOutput("rd_byte", {24'b0, hyper_dq_o}, {24'b0, byteQ.pop_front()});
                end
                if (firstByte) checkOutput("first_byte_edge", edgeCnt, 32'd25);
                else checkOutput("byte_per_edge", edgeCnt, lastByteEdge + 1);
                firstByte    = 1'b0;
                lastByteEdge = edgeCnt;
            end
            prevRwds = hyper_rwds_o;
        end
    end

    initial begin
        rst_ni         = 1'b0;
        hyper_cs_ni    = 1'b1;
        hyper_ck_i     = 1'b0;
        hyper_reset_ni = 1'b1;
        hyper_dq_i     = 8'h00;
        hyper_rwds_i   = 1'b0;
        mem_rdata_i    = 16'h0000;
        sram[16'h0011] = 16'hCDEF;
        sram[16'h001E] = 16'h0123;
        sram[16'h001F] = 16'h4567;
        sram[16'h0020] = 16'hDEAD;
        sram[16'h0021] = 16'hBEEF;
        sram[16'h0022] = 16'h5A3C;
        repeat (3) @(negedge clk_i);
        checkOutput("rst_dq", {24'b0, hyper_dq_o}, 32'd0);
        checkOutput("rst_dq_oe", {31'b0, hyper_dq_oe_o}, 32'd0);
        checkOutput("rst_rwds", {31'b0, hyper_rwds_o}, 32'd0);
        checkOutput("rst_rwds_oe", {31'b0, hyper_rwds_oe_o}, 32'd0);
        checkOutput("rst_mem_req", {31'b0, mem_req_o}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we_o}, 32'd0);
        checkOutput("rst_mem_addr", {16'b0, mem_addr_o}, 32'd0);
        checkOutput("rst_mem_wdata", {16'b0, mem_wdata_o}, 32'd0);
        checkOutput("rst_mem_be", {30'b0, mem_be_o}, 32'd0);
        rst_ni = 1'b1;
        repeat (4) @(negedge clk_i);

        $display("[TB] linear write of 2 words at 0x0010");
        pushOp(1'b1, 16'h0010, 16'hA1B2, 2'b11, 26);
        pushOp(1'b1, 16'h0011, 16'hC3D4, 2'b10, 28);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h10, {16'h0, 16'h0, 16'hC3D4, 16'hA1B2},
                      {2'b00, 2'b00, 2'b01, 2'b00}, 4);

        $display("[TB] linear read of 3 words at 0x0020");
        pushOp(1'b0, 16'h0020, 16'h0, 2'b00, 6);
        pushOp(1'b0, 16'h0021, 16'h0, 2'b00, 26);
        pushOp(1'b0, 16'h0022, 16'h0, 2'b00, 28);
        pushOp(1'b0, 16'h0023, 16'h0, 2'b00, 30);
        pushBytes(64'hDEAD_BEEF_5A3C_0000, 6);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h20, '0, '0, 6);

        $display("[TB] wrapped read of 4 words from 0x001E, edges 2 clocks apart");
        halfClk = 2;
        pushOp(1'b0, 16'h001E, 16'h0, 2'b00, 6);
        pushOp(1'b0, 16'h001F, 16'h0, 2'b00, 26);
        pushOp(1'b0, 16'h0010, 16'h0, 2'b00, 28);
        pushOp(1'b0, 16'h0011, 16'h0, 2'b00, 30);
        pushOp(1'b0, 16'h0012, 16'h0, 2'b00, 32);
        pushBytes(64'h0123_4567_A1B2_C3EF, 8);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h1E, '0, '0, 8);
        halfClk = 3;

        $display("[TB] CS rises after one write byte, then a normal write");
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h40, {16'h0, 16'h0, 16'h0, 16'h7788}, '0, 1);
        pushOp(1'b1, 16'h0041, 16'h55AA, 2'b11, 26);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h41, {16'h0, 16'h0, 16'h0, 16'h55AA}, '0, 2);

        $display("[TB] register write CR0, read CR0 and ID0");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h800, {16'h0, 16'h0, 16'h0, 16'h1234}, '0, 2);
`ifdef HYPERBUS_DEV_REG_SPACE_EN
        pushBytes(64'h1234_0000_0000_0000, 2);
`else
        pushBytes(64'h0000_0000_0000_0000, 2);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h800, '0, '0, 2);
`ifdef HYPERBUS_DEV_REG_SPACE_EN
        pushBytes(64'h0C81_0000_0000_0000, 2);
`else
        pushBytes(64'h0000_0000_0000_0000, 2);
`endif
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h000, '0, '0, 2);

        repeat (5) @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
